inv_mix_columns: RTL and testbench

//  AES InvMixColumns stage for the decrypt datapath, the inverse of the encrypt-side MixColumns.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/inv_mix_column_word.sv | 37 +++
 rtl/inv_mix_columns.sv | 108 ++++++++++
 tb/tb_inv_mix_columns.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers (reduction polynomial 0x11b) used by the MixColumns stages.
package aes_pkg;

  localparam int COL_W  = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE_S,
    RUN_S,
    DONE_S
  } mix_state_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant operand this folds to a few XOR levels.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column (row r byte at [8r +: 8]).
// With INV_MIX_FWD_EN defined, mode_i=1 selects forward MixColumns instead.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
`ifdef INV_MIX_FWD_EN
  input  logic             mode_i,
`endif
  output logic [COL_W-1:0] col_o
);

  logic [BYTE_W-1:0] w_b   [4];
  logic [BYTE_W-1:0] w_inv [4];
`ifdef INV_MIX_FWD_EN
  logic [BYTE_W-1:0] w_fwd [4];
`endif

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;

    assign w_b[r] = col_i[BYTE_W*r +: BYTE_W];

    assign w_inv[r] = gf_mul(w_b[r],  8'h0e) ^ gf_mul(w_b[R1], 8'h0b)
                    ^ gf_mul(w_b[R2], 8'h0d) ^ gf_mul(w_b[R3], 8'h09);

`ifdef INV_MIX_FWD_EN
    assign w_fwd[r] = xtime(w_b[r]) ^ xtime(w_b[R1]) ^ w_b[R1] ^ w_b[R2] ^ w_b[R3];
    assign col_o[BYTE_W*r +: BYTE_W] = mode_i ? w_fwd[r] : w_inv[r];
`else
    assign col_o[BYTE_W*r +: BYTE_W] = w_inv[r];
`endif
  end

endmodule

// File: rtl/inv_mix_columns.sv
// Column-serial AES InvMixColumns, start/done handshake; result and done pulse NUM_COLS+1 edges after start.
// INV_MIX_FWD_EN adds mode_i so the same instance can also run forward MixColumns.
module inv_mix_columns
  import aes_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_i,
  input  logic             start_i,
`ifdef INV_MIX_FWD_EN
  input  logic             mode_i,
`endif
  output logic [WIDTH-1:0] s_o,
  output logic             done_o
);

  localparam int NUM_COLS = WIDTH / COL_W;
  localparam int IDX_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  mix_state_t       r_state;
  mix_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_col_idx;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s_out;
  logic             r_done;
`ifdef INV_MIX_FWD_EN
  logic             r_mode;
`endif

  logic [COL_W-1:0] w_col_in;
  logic [COL_W-1:0] w_col_out;
  logic             w_last_col;
  logic             w_capture;

  assign w_last_col = (r_col_idx == IDX_W'(NUM_COLS - 1));
  assign w_capture  = (r_state == IDLE_S) && start_i;

  always_comb begin
    w_col_in = r_op[COL_W-1:0];
    for (int c = 0; c < NUM_COLS; c++) begin
      if (r_col_idx == IDX_W'(c)) w_col_in = r_op[c*COL_W +: COL_W];
    end
  end

  inv_mix_column_word u_word (
    .col_i  (w_col_in),
`ifdef INV_MIX_FWD_EN
    .mode_i (r_mode),
`endif
    .col_o  (w_col_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE_S;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE_S:  if (start_i) w_state_nxt = RUN_S;
      RUN_S:   if (w_last_col) w_state_nxt = DONE_S;
      DONE_S:  w_state_nxt = IDLE_S;
      default: w_state_nxt = IDLE_S;
    endcase
  end

  // s_i is only looked at on the capture edge; the run works entirely from r_op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_res     <= '0;
      r_col_idx <= '0;
      r_s_out   <= '0;
      r_done    <= 1'b0;
`ifdef INV_MIX_FWD_EN
      r_mode    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_op      <= s_i;
        r_res     <= '0;
        r_col_idx <= '0;
`ifdef INV_MIX_FWD_EN
        r_mode    <= mode_i;
`endif
      end
      if (r_state == RUN_S) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (r_col_idx == IDX_W'(c)) r_res[c*COL_W +: COL_W] <= w_col_out;
        end
        r_col_idx <= w_last_col ? '0 : r_col_idx + IDX_W'(1);
      end
      if (r_state == DONE_S) begin
        r_s_out <= r_res;
        r_done  <= 1'b1;
      end
    end
  end

  assign s_o    = r_s_out;
  assign done_o = r_done;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed bench for inv_mix_columns: latency, column values, handshake, reset abort, back-to-back.
module tb_inv_mix_columns;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] s_i = '0;
  logic [127:0] s_o;
  logic         done_o;
`ifdef INV_MIX_FWD_EN
  logic         mode_i = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inv_mix_columns #(.WIDTH(128)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_i     (s_i),
    .start_i (start_i),
`ifdef INV_MIX_FWD_EN
    .mode_i  (mode_i),
`endif
    .s_o     (s_o),
    .done_o  (done_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rep4(input logic [31:0] c);
    return {c, c, c, c};
  endfunction

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called 1ns after a rising edge; returns 1ns after the capture edge with s_i scrambled.
  task automatic start_run(input logic [127:0] st, input logic md);
    s_i     = st;
    start_i = 1'b1;
`ifdef INV_MIX_FWD_EN
    mode_i  = md;
`else
    if (md) $display("note: mode ignored in inverse-only build");
`endif
    @(posedge clk); #1;
    start_i = 1'b0;
    s_i     = junk();
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  logic [127:0] mixed_in;
  logic [127:0] mixed_exp;
  logic [127:0] vec  [3];
  logic [127:0] vexp [3];

  initial begin
    int lat;
    int pulses;
    mixed_in  = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    mixed_exp = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
    vec[0] = rep4(32'hbca14d8e);  vexp[0] = rep4(32'h455313db);
    vec[1] = rep4(32'h01010101);  vexp[1] = rep4(32'h01010101);
    vec[2] = rep4(32'h9d58dc9f);  vexp[2] = rep4(32'h5c220af2);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_o", s_o, '0);
    check("rst_done", 128'(done_o), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 column, latency and single-cycle pulse
    start_run(vec[0], 1'b0);
    wait_done(lat);
    check("t1_latency", 128'(lat), 128'(5));
    check("t1_s_o", s_o, vexp[0]);
    @(posedge clk); #1;
    check("t1_pulse_width", 128'(done_o), 128'(0));

    // Distinct columns
    start_run(mixed_in, 1'b0);
    wait_done(lat);
    check("t2_latency", 128'(lat), 128'(5));
    check("t2_s_o", s_o, mixed_exp);
    @(posedge clk); #1;

    // start_i held high: one run every 6 cycles, inputs only matter at capture
    s_i     = vec[0];
    start_i = 1'b1;
    @(posedge clk); #1;
    for (int t = 1; t <= 17; t++) begin
      int ph;
      int run;
      @(posedge clk); #1;
      ph  = ((t - 1) % 6) + 1;
      run = (t - 1) / 6;
      check($sformatf("t3_done_c%0d", t), 128'(done_o), 128'(ph == 5));
      if (ph == 5) begin
        check($sformatf("t3_s_o_run%0d", run), s_o, vexp[run]);
        s_i = (run < 2) ? vec[run+1] : junk();
      end else begin
        s_i = junk();
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;

    // Reset while RUN is on column 2
    start_run(vec[2], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t4_rst_s_o", s_o, '0);
    check("t4_rst_done", 128'(done_o), 128'(0));
    @(posedge clk); #1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    check("t4_no_done_after_abort", 128'(pulses), 128'(0));
    check("t4_s_o_still_zero", s_o, '0);
    start_run(vec[2], 1'b0);
    wait_done(lat);
    check("t4_recover_latency", 128'(lat), 128'(5));
    check("t4_recover_s_o", s_o, vexp[2]);
    @(posedge clk); #1;

    // Back-to-back: start in the done_o cycle
    start_run(mixed_in, 1'b0);
    wait_done(lat);
    check("t6_first_latency", 128'(lat), 128'(5));
    check("t6_first_s_o", s_o, mixed_exp);
    s_i     = vec[0];
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    s_i     = junk();
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("t6_done_k%0d", k), 128'(done_o), 128'(k == 5));
      check($sformatf("t6_s_o_k%0d", k), s_o, (k == 5) ? vexp[0] : mixed_exp);
    end
    @(posedge clk); #1;

`ifdef INV_MIX_FWD_EN
    // Forward mode and round trip
    start_run(rep4(32'h455313db), 1'b1);
    wait_done(lat);
    check("t5_fwd_latency", 128'(lat), 128'(5));
    check("t5_fwd_s_o", s_o, rep4(32'hbca14d8e));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      logic [127:0] orig;
      orig = junk();
      start_run(orig, 1'b1);
      wait_done(lat);
      check($sformatf("t5_rt_fwd_lat%0d", i), 128'(lat), 128'(5));
      @(posedge clk); #1;
      start_run(s_o, 1'b0);
      wait_done(lat);
      check($sformatf("t5_rt_inv_lat%0d", i), 128'(lat), 128'(5));
      check($sformatf("t5_roundtrip%0d", i), s_o, orig);
      @(posedge clk); #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
